// File: rtl/sfq_pkg.sv
// sfq_pkg: shared types and constants for the SFQ pulse bank.
//  - sfq_tx_state_e : per-channel TX state (idle / pulse high / enforced gap)
//  - SFQ_PW_DEF, SFQ_MIN_GAP_DEF : default pulse width and gap in clk cycles
//  - sfq_cnt_w()    : width of a counter that must hold values 0..n-1
package sfq_pkg;

   typedef enum logic [1:0] {
      SFQ_IDLE  = 2'd0,
      SFQ_PULSE = 2'd1,
      SFQ_GAP   = 2'd2
   } sfq_tx_state_e;

   localparam int SFQ_PW_DEF      = 2;
   localparam int SFQ_MIN_GAP_DEF = 1;

   // Never returns 0 so a degenerate phase counter still has one bit.
   function automatic int sfq_cnt_w(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/sfq_channel.sv
// sfq_channel: one SFQ channel = TX pulse generator with pending-send queue
// counter, plus RX edge latch (and optional RX edge counter).
// Optional feature macro: SFQ_RX_CNT_EN (adds o_rx_cnt and the counter).
// Ports:
//  clk, rst   clock, synchronous active-high reset
//  i_send     one-cycle request for one TX pulse
//  i_pulse    RX pulse input (synchronous to clk)
//  i_clear    clears RX latch, overflow flag (and RX count)
//  o_pulse    TX pulse, high for exactly PW cycles per accepted request
//  o_busy     channel pulsing, in gap, or holding queued requests
//  o_ovf      sticky: a request was dropped because the queue was full
//  o_data     RX latch, set by a rising edge of i_pulse
//  o_rx_cnt   saturating count of RX edges (SFQ_RX_CNT_EN only)
module sfq_channel
   import sfq_pkg::*;
#(
   parameter int PW      = SFQ_PW_DEF,
   parameter int MIN_GAP = SFQ_MIN_GAP_DEF,
   parameter int PEND_W  = 3
`ifdef SFQ_RX_CNT_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic i_send,
   input  logic i_pulse,
   input  logic i_clear,
   output logic o_pulse,
   output logic o_busy,
   output logic o_ovf,
   output logic o_data
`ifdef SFQ_RX_CNT_EN
   , output logic [CNT_W-1:0] o_rx_cnt
`endif
);

   localparam int PH_MAX = (PW > MIN_GAP) ? PW : MIN_GAP;
   localparam int PH_W   = sfq_cnt_w(PH_MAX);
   localparam logic [PH_W-1:0]   PW_LAST  = PH_W'(PW - 1);
   localparam logic [PH_W-1:0]   GAP_LAST = PH_W'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
   localparam bit                HAS_GAP  = (MIN_GAP > 0);

   sfq_tx_state_e     r_state;
   logic [PH_W-1:0]   r_phase;
   logic [PEND_W-1:0] r_pend;
   logic              r_pulse, r_busy, r_ovf, r_data, r_pin_q;

   sfq_tx_state_e     w_state_nx;
   logic [PH_W-1:0]   w_phase_nx;
   logic [PEND_W-1:0] w_pend_nx;
   logic              w_take, w_deq, w_enq, w_drop, w_edge;
   logic              w_ovf_nx, w_data_nx, w_pulse_nx, w_busy_nx;

   // Next-state logic. w_take: this cycle's request starts a pulse directly
   // (never enters the queue); w_deq: a queued request starts the next pulse.
   always_comb begin
      w_state_nx = r_state;
      w_phase_nx = r_phase;
      w_take     = 1'b0;
      w_deq      = 1'b0;
      case (r_state)
         SFQ_IDLE: begin
            if (i_send) begin
               w_state_nx = SFQ_PULSE;
               w_phase_nx = {PH_W{1'b0}};
               w_take     = 1'b1;
            end else begin
               w_state_nx = SFQ_IDLE;
            end
         end
         SFQ_PULSE: begin
            if (r_phase != PW_LAST) begin
               w_phase_nx = r_phase + PH_W'(1'b1);
            end else if (HAS_GAP) begin
               w_state_nx = SFQ_GAP;
               w_phase_nx = {PH_W{1'b0}};
            end else if (r_pend != {PEND_W{1'b0}}) begin
               w_state_nx = SFQ_PULSE;
               w_phase_nx = {PH_W{1'b0}};
               w_deq      = 1'b1;
            end else if (i_send) begin
               w_state_nx = SFQ_PULSE;
               w_phase_nx = {PH_W{1'b0}};
               w_take     = 1'b1;
            end else begin
               w_state_nx = SFQ_IDLE;
               w_phase_nx = {PH_W{1'b0}};
            end
         end
         SFQ_GAP: begin
            if (r_phase != GAP_LAST) begin
               w_phase_nx = r_phase + PH_W'(1'b1);
            end else if (r_pend != {PEND_W{1'b0}}) begin
               w_state_nx = SFQ_PULSE;
               w_phase_nx = {PH_W{1'b0}};
               w_deq      = 1'b1;
            end else if (i_send) begin
               // A request landing on the last gap cycle with an empty queue
               // is served directly rather than bouncing through the queue.
               w_state_nx = SFQ_PULSE;
               w_phase_nx = {PH_W{1'b0}};
               w_take     = 1'b1;
            end else begin
               w_state_nx = SFQ_IDLE;
               w_phase_nx = {PH_W{1'b0}};
            end
         end
         default: begin
            w_state_nx = SFQ_IDLE;
            w_phase_nx = {PH_W{1'b0}};
         end
      endcase
   end

   // Pending queue, overflow flag and RX latch next values.
   always_comb begin
      w_enq     = i_send & ~w_take;
      w_drop    = 1'b0;
      w_pend_nx = r_pend;
      if (w_enq && w_deq) begin
         w_pend_nx = r_pend;
      end else if (w_enq) begin
         if (r_pend == PEND_MAX) begin
            w_drop = 1'b1;
         end else begin
            w_pend_nx = r_pend + PEND_W'(1'b1);
         end
      end else if (w_deq) begin
         w_pend_nx = r_pend - PEND_W'(1'b1);
      end else begin
         w_pend_nx = r_pend;
      end

      w_edge = i_pulse & ~r_pin_q;

      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
         w_ovf_nx = 1'b1;
      end else if (i_clear) begin
         w_ovf_nx = 1'b0;
      end else begin
         w_ovf_nx = r_ovf;
      end

      // An edge coinciding with a clear wins.
      if (w_edge) begin
         w_data_nx = 1'b1;
      end else if (i_clear) begin
         w_data_nx = 1'b0;
      end else begin
         w_data_nx = r_data;
      end
   end

   // Output decode from next-state values, so the outputs are registered.
   always_comb begin
      w_pulse_nx = (w_state_nx == SFQ_PULSE);
      w_busy_nx  = (w_state_nx != SFQ_IDLE) || (w_pend_nx != {PEND_W{1'b0}});
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= SFQ_IDLE;
         r_phase <= {PH_W{1'b0}};
         r_pend  <= {PEND_W{1'b0}};
         r_pulse <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
         r_data  <= 1'b0;
         r_pin_q <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_phase <= w_phase_nx;
         r_pend  <= w_pend_nx;
         r_pulse <= w_pulse_nx;
         r_busy  <= w_busy_nx;
         r_ovf   <= w_ovf_nx;
         r_data  <= w_data_nx;
         r_pin_q <= i_pulse;
      end
   end

   assign o_pulse = r_pulse;
   assign o_busy  = r_busy;
   assign o_ovf   = r_ovf;
   assign o_data  = r_data;

`ifdef SFQ_RX_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;

   // RX edge count: saturating; a clear with a coincident edge loads 1.
   always_comb begin
      w_cnt_nx = r_cnt;
      if (i_clear) begin
         if (w_edge) begin
            w_cnt_nx = CNT_W'(1'b1);
         end else begin
            w_cnt_nx = {CNT_W{1'b0}};
         end
      end else if (w_edge && (r_cnt != CNT_MAX)) begin
         w_cnt_nx = r_cnt + CNT_W'(1'b1);
      end else begin
         w_cnt_nx = r_cnt;
      end
   end

   // RX edge count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= {CNT_W{1'b0}};
      end else begin
         r_cnt <= w_cnt_nx;
      end
   end

   assign o_rx_cnt = r_cnt;
`endif

endmodule

// File: rtl/sfq_pulse_bank.sv
// sfq_pulse_bank: NCH independent SFQ channels (TX pulse generator with
// request queue + RX edge latch). The top only slices vector ports.
// Optional feature macro: SFQ_RX_CNT_EN (adds rx_cnt_o and CNT_W).
// Ports:
//  clk, rst   clock, synchronous active-high reset
//  send_i     per-channel pulse request     pulse_o  per-channel TX pulse
//  busy_o     channel active or queued      ovf_o    sticky request-dropped flag
//  pulse_i    RX pulse inputs               clear_i  clear RX latch / ovf_o
//  data_o     RX latches                    rx_cnt_o RX counts, ch c at [c*CNT_W +: CNT_W]
module sfq_pulse_bank
   import sfq_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int PW      = SFQ_PW_DEF,
   parameter int MIN_GAP = SFQ_MIN_GAP_DEF,
   parameter int PEND_W  = 3
`ifdef SFQ_RX_CNT_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] send_i,
   output logic [NCH-1:0] pulse_o,
   output logic [NCH-1:0] busy_o,
   output logic [NCH-1:0] ovf_o,
   input  logic [NCH-1:0] pulse_i,
   input  logic [NCH-1:0] clear_i,
   output logic [NCH-1:0] data_o
`ifdef SFQ_RX_CNT_EN
   , output logic [NCH*CNT_W-1:0] rx_cnt_o
`endif
);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      sfq_channel #(
         .PW      (PW),
         .MIN_GAP (MIN_GAP),
         .PEND_W  (PEND_W)
`ifdef SFQ_RX_CNT_EN
         , .CNT_W (CNT_W)
`endif
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .i_send  (send_i[c]),
         .i_pulse (pulse_i[c]),
         .i_clear (clear_i[c]),
         .o_pulse (pulse_o[c]),
         .o_busy  (busy_o[c]),
         .o_ovf   (ovf_o[c]),
         .o_data  (data_o[c])
`ifdef SFQ_RX_CNT_EN
         , .o_rx_cnt (rx_cnt_o[c*CNT_W +: CNT_W])
`endif
      );
   end

endmodule

// File: tb/tb_sfq_pulse_bank.sv
// Self-checking bench for sfq_pulse_bank. The reference model keeps, per
// channel, a list of accepted requests with the cycle their pulse starts:
// start = max(request+1, previous start + PW + MIN_GAP).
module tb_sfq_pulse_bank;

   localparam int NCH      = 4;
   localparam int PW       = 2;
   localparam int MIN_GAP  = 1;
   localparam int PEND_W   = 3;
   localparam int PEND_MAX = (1 << PEND_W) - 1;
   localparam int CNT_W    = 8;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] send_i, pulse_i, clear_i;
   logic [NCH-1:0] pulse_o, busy_o, ovf_o, data_o;
`ifdef SFQ_RX_CNT_EN
   logic [NCH*CNT_W-1:0] rx_cnt_o;
`endif

   sfq_pulse_bank #(
      .NCH(NCH), .PW(PW), .MIN_GAP(MIN_GAP), .PEND_W(PEND_W)
`ifdef SFQ_RX_CNT_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk), .rst(rst), .send_i(send_i), .pulse_o(pulse_o),
      .busy_o(busy_o), .ovf_o(ovf_o), .pulse_i(pulse_i),
      .clear_i(clear_i), .data_o(data_o)
`ifdef SFQ_RX_CNT_EN
      , .rx_cnt_o(rx_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   // reference model state
   int q_req   [NCH][$];
   int q_start [NCH][$];
   int last_start [NCH];
   int n_acc   [NCH];
   bit m_ovf [NCH], m_data [NCH], m_pinq [NCH];
   int m_cnt [NCH];

   task automatic model_clear();
      for (int ch = 0; ch < NCH; ch++) begin
         q_req[ch].delete();
         q_start[ch].delete();
         last_start[ch] = -1000;
         n_acc[ch] = 0;
         m_ovf[ch] = 1'b0; m_data[ch] = 1'b0; m_pinq[ch] = 1'b0; m_cnt[ch] = 0;
      end
   endtask

   // advance the model by the inputs applied in cycle cyc
   task automatic model_step();
      bit edge_b, drop, deq;
      int pend, s;
      if (rst) begin
         model_clear();
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            edge_b = pulse_i[ch] && !m_pinq[ch];
            if (edge_b) m_data[ch] = 1'b1;
            else if (clear_i[ch]) m_data[ch] = 1'b0;
            if (clear_i[ch]) m_cnt[ch] = edge_b ? 1 : 0;
            else if (edge_b && m_cnt[ch] < CNT_MAX) m_cnt[ch]++;
            m_pinq[ch] = pulse_i[ch];
            drop = 1'b0;
            if (send_i[ch]) begin
               pend = 0;
               deq  = 1'b0;
               for (int k = 0; k < q_req[ch].size(); k++) begin
                  if (q_req[ch][k] < cyc && q_start[ch][k] > cyc) pend++;
                  if (q_req[ch][k] < cyc && q_start[ch][k] == cyc + 1) deq = 1'b1;
               end
               if (pend == PEND_MAX && !deq) begin
                  drop = 1'b1;
               end else begin
                  s = cyc + 1;
                  if (last_start[ch] + PW + MIN_GAP > s) s = last_start[ch] + PW + MIN_GAP;
                  q_req[ch].push_back(cyc);
                  q_start[ch].push_back(s);
                  last_start[ch] = s;
                  n_acc[ch]++;
               end
            end
            if (drop) m_ovf[ch] = 1'b1;
            else if (clear_i[ch]) m_ovf[ch] = 1'b0;
            while (q_start[ch].size() > 0 && q_start[ch][0] + PW + MIN_GAP + 2 < cyc) begin
               void'(q_start[ch].pop_front());
               void'(q_req[ch].pop_front());
            end
         end
      end
   endtask

   function automatic logic [NCH-1:0] exp_pulse();
      logic [NCH-1:0] v;
      v = {NCH{1'b0}};
      for (int ch = 0; ch < NCH; ch++)
         for (int k = 0; k < q_start[ch].size(); k++)
            if (q_start[ch][k] <= cyc && cyc < q_start[ch][k] + PW) v[ch] = 1'b1;
      return v;
   endfunction

   function automatic logic [NCH-1:0] exp_busy();
      logic [NCH-1:0] v;
      v = {NCH{1'b0}};
      for (int ch = 0; ch < NCH; ch++)
         for (int k = 0; k < q_start[ch].size(); k++) begin
            if (q_start[ch][k] <= cyc && cyc < q_start[ch][k] + PW + MIN_GAP) v[ch] = 1'b1;
            if (q_req[ch][k] < cyc && q_start[ch][k] > cyc) v[ch] = 1'b1;
         end
      return v;
   endfunction

   function automatic logic [NCH-1:0] exp_ovf();
      logic [NCH-1:0] v;
      for (int ch = 0; ch < NCH; ch++) v[ch] = m_ovf[ch];
      return v;
   endfunction

   function automatic logic [NCH-1:0] exp_data();
      logic [NCH-1:0] v;
      for (int ch = 0; ch < NCH; ch++) v[ch] = m_data[ch];
      return v;
   endfunction

   function automatic logic [NCH*CNT_W-1:0] exp_cnt();
      logic [NCH*CNT_W-1:0] v;
      for (int ch = 0; ch < NCH; ch++) v[ch*CNT_W +: CNT_W] = CNT_W'(m_cnt[ch]);
      return v;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1; send_i = 4'b1111; pulse_i = 4'b1111; clear_i = 4'b0000;
      tick();
      tick();
      rst = 1'b0; send_i = 4'b0000; pulse_i = 4'b0000;
      vecs++; if (pulse_o !== 4'b0000) begin errs++; $display("FAIL reset_pulse got %b exp 0000", pulse_o); end
      vecs++; if (busy_o !== 4'b0000) begin errs++; $display("FAIL reset_busy got %b exp 0000", busy_o); end
      vecs++; if (ovf_o !== 4'b0000) begin errs++; $display("FAIL reset_ovf got %b exp 0000", ovf_o); end
      vecs++; if (data_o !== 4'b0000) begin errs++; $display("FAIL reset_data got %b exp 0000", data_o); end
`ifdef SFQ_RX_CNT_EN
      vecs++; if (rx_cnt_o !== '0) begin errs++; $display("FAIL reset_cnt got %h exp 0", rx_cnt_o); end
`endif
   endtask

   task automatic test_single_pulse();
      int hi;
      hi = 0;
      send_i = 4'b0001;
      tick();
      send_i = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         if (pulse_o[0] === 1'b1) hi++;
         vecs++; if (pulse_o !== exp_pulse()) begin errs++; $display("FAIL single_pulse cyc %0d got %b exp %b", cyc, pulse_o, exp_pulse()); end
         vecs++; if (busy_o !== exp_busy()) begin errs++; $display("FAIL single_busy cyc %0d got %b exp %b", cyc, busy_o, exp_busy()); end
         tick();
      end
      vecs++; if (hi !== PW) begin errs++; $display("FAIL single_width got %0d exp %0d", hi, PW); end
      vecs++; if (busy_o[0] !== 1'b0) begin errs++; $display("FAIL single_idle got %b exp 0", busy_o[0]); end
   endtask

   task automatic test_back_to_back();
      int hi;
      hi = 0;
      for (int i = 0; i < 14; i++) begin
         send_i = (i < 3) ? 4'b0010 : 4'b0000;
         tick();
         if (pulse_o[1] === 1'b1) hi++;
         vecs++; if (pulse_o !== exp_pulse()) begin errs++; $display("FAIL b2b_pulse cyc %0d got %b exp %b", cyc, pulse_o, exp_pulse()); end
         vecs++; if (busy_o !== exp_busy()) begin errs++; $display("FAIL b2b_busy cyc %0d got %b exp %b", cyc, busy_o, exp_busy()); end
      end
      vecs++; if (hi !== 3 * PW) begin errs++; $display("FAIL b2b_count got %0d exp %0d", hi, 3 * PW); end
      vecs++; if (ovf_o[1] !== 1'b0) begin errs++; $display("FAIL b2b_ovf got %b exp 0", ovf_o[1]); end
   endtask

   task automatic test_overflow();
      int hi;
      hi = 0;
      for (int i = 0; i < 45; i++) begin
         send_i = (i < 14) ? 4'b0100 : 4'b0000;
         tick();
         if (pulse_o[2] === 1'b1) hi++;
         vecs++; if (pulse_o !== exp_pulse()) begin errs++; $display("FAIL ovf_pulse cyc %0d got %b exp %b", cyc, pulse_o, exp_pulse()); end
         vecs++; if (busy_o !== exp_busy()) begin errs++; $display("FAIL ovf_busy cyc %0d got %b exp %b", cyc, busy_o, exp_busy()); end
         vecs++; if (ovf_o !== exp_ovf()) begin errs++; $display("FAIL ovf_flag cyc %0d got %b exp %b", cyc, ovf_o, exp_ovf()); end
      end
      vecs++; if (ovf_o[2] !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b exp 1", ovf_o[2]); end
      vecs++; if (hi !== n_acc[2] * PW || n_acc[2] >= 14) begin errs++; $display("FAIL ovf_pulses got %0d exp %0d (accepted %0d)", hi, n_acc[2] * PW, n_acc[2]); end
      clear_i = 4'b0100;
      tick();
      clear_i = 4'b0000;
      vecs++; if (ovf_o[2] !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b exp 0", ovf_o[2]); end
   endtask

   task automatic test_rx_race();
      pulse_i = 4'b0000; tick();
      pulse_i = 4'b0100; clear_i = 4'b0100; tick();
      vecs++; if (data_o[2] !== 1'b1) begin errs++; $display("FAIL rx_race got %b exp 1", data_o[2]); end
      vecs++; if (data_o !== exp_data()) begin errs++; $display("FAIL rx_race_model got %b exp %b", data_o, exp_data()); end
      tick();
      vecs++; if (data_o[2] !== 1'b0) begin errs++; $display("FAIL rx_clear got %b exp 0", data_o[2]); end
      pulse_i = 4'b0000; clear_i = 4'b0000; tick();
   endtask

   task automatic test_reset_mid_pulse();
      int hi;
      hi = 0;
      send_i = 4'b1000; tick();
      tick();
      rst = 1'b1; tick();
      rst = 1'b0; send_i = 4'b0000;
      vecs++; if (pulse_o[3] !== 1'b0) begin errs++; $display("FAIL rst_mid_pulse got %b exp 0", pulse_o[3]); end
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pulse_o[3] === 1'b1 || busy_o[3] === 1'b1) hi++;
      end
      vecs++; if (hi !== 0) begin errs++; $display("FAIL rst_mid_after got %0d active cycles exp 0", hi); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            send_i[ch]  = ($urandom_range(0, 9) < 4);
            pulse_i[ch] = $urandom_range(0, 1) == 1;
            clear_i[ch] = ($urandom_range(0, 7) == 0);
         end
         rst = ($urandom_range(0, 199) == 0);
         tick();
         vecs++; if (pulse_o !== exp_pulse()) begin errs++; $display("FAIL rand_pulse cyc %0d got %b exp %b", cyc, pulse_o, exp_pulse()); end
         vecs++; if (busy_o !== exp_busy()) begin errs++; $display("FAIL rand_busy cyc %0d got %b exp %b", cyc, busy_o, exp_busy()); end
         vecs++; if (ovf_o !== exp_ovf()) begin errs++; $display("FAIL rand_ovf cyc %0d got %b exp %b", cyc, ovf_o, exp_ovf()); end
         vecs++; if (data_o !== exp_data()) begin errs++; $display("FAIL rand_data cyc %0d got %b exp %b", cyc, data_o, exp_data()); end
`ifdef SFQ_RX_CNT_EN
         vecs++; if (rx_cnt_o !== exp_cnt()) begin errs++; $display("FAIL rand_cnt cyc %0d got %h exp %h", cyc, rx_cnt_o, exp_cnt()); end
`endif
      end
      rst = 1'b0; send_i = 4'b0000; pulse_i = 4'b0000; clear_i = 4'b0000;
      tick();
   endtask

`ifdef SFQ_RX_CNT_EN
   task automatic test_rx_cnt();
      clear_i = 4'b1000; tick(); clear_i = 4'b0000;
      for (int i = 0; i < 2 * (CNT_MAX + 3); i++) begin
         pulse_i = (i % 2 == 0) ? 4'b1000 : 4'b0000;
         tick();
      end
      vecs++; if (rx_cnt_o[3*CNT_W +: CNT_W] !== CNT_W'(CNT_MAX)) begin errs++; $display("FAIL rx_cnt_sat got %0d exp %0d", rx_cnt_o[3*CNT_W +: CNT_W], CNT_MAX); end
      clear_i = 4'b1000; pulse_i = 4'b0000; tick(); clear_i = 4'b0000;
      vecs++; if (rx_cnt_o[3*CNT_W +: CNT_W] !== '0) begin errs++; $display("FAIL rx_cnt_clear got %0d exp 0", rx_cnt_o[3*CNT_W +: CNT_W]); end
   endtask
`endif

   initial begin
      rst = 1'b1; send_i = 4'b0000; pulse_i = 4'b0000; clear_i = 4'b0000;
      model_clear();
      @(posedge clk); #1;
      test_reset();
      test_single_pulse();
      test_back_to_back();
      test_overflow();
      test_rx_race();
      test_reset_mid_pulse();
`ifdef SFQ_RX_CNT_EN
      test_rx_cnt();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
